// File: rtl/dds_sequencer_if.sv
// Bundles the configuration handshake, run control, ROM port and DAC sample outputs of
// dds_sequencer. The master modport is the surrounding system (config source, registered
// ROM and DAC driver); the slave modport is the sequencer itself.
// Optional: define DDS_PHASE_OFFSET_EN to add cfg_phase (programmable start/stop phase).
interface dds_sequencer_if #(
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DIV_WIDTH  = 16
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [ACC_WIDTH-1:0]  cfg_step;
    logic [DIV_WIDTH-1:0]  cfg_div;
`ifdef DDS_PHASE_OFFSET_EN
    logic [ACC_WIDTH-1:0]  cfg_phase;
`endif
    logic                  start;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] sample;
    logic                  sample_valid;
    logic                  busy;

`ifdef DDS_PHASE_OFFSET_EN
    modport master (
        output cfg_valid, cfg_step, cfg_div, cfg_phase, start, stop, rom_data,
        input  cfg_ready, rom_addr, sample, sample_valid, busy
    );
    modport slave (
        input  cfg_valid, cfg_step, cfg_div, cfg_phase, start, stop, rom_data,
        output cfg_ready, rom_addr, sample, sample_valid, busy
    );
`else
    modport master (
        output cfg_valid, cfg_step, cfg_div, start, stop, rom_data,
        input  cfg_ready, rom_addr, sample, sample_valid, busy
    );
    modport slave (
        input  cfg_valid, cfg_step, cfg_div, start, stop, rom_data,
        output cfg_ready, rom_addr, sample, sample_valid, busy
    );
`endif
endinterface

// File: rtl/dds_sequencer.sv
// Phase-accumulator sequencer for the quarter-wave sine DAC path. Each sample tick turns the
// accumulator phase into a quarter-wave ROM address, and three cycles later the returned ROM
// word is folded into a full-cycle DAC sample.
// Optional: define DDS_PHASE_OFFSET_EN to start (and stop) at cfg_phase instead of phase 0.
module dds_sequencer #(
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dds_sequencer_if.slave bus
);
    localparam int unsigned IdxW = ADDR_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] MidScale = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StStopping, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  step_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  v1_q, v2_q;
    // Only the lower-half flag of the quadrant needs to travel with the ROM read.
    logic                  neg1_q, neg2_q;
    logic [DATA_WIDTH-1:0] sample_q;
    logic                  sv_q;

    logic                  cfg_ready;
    logic                  busy;
    logic                  tick_slot;
    logic                  tick;
    logic                  cfg_fire;
    logic [ACC_WIDTH-1:0]  base_phase;
    logic [ACC_WIDTH-1:0]  start_acc;
    logic [ACC_WIDTH-1:0]  acc_rel;
    logic [ACC_WIDTH:0]    rel_sum;
    logic                  carry;
    logic [IdxW-1:0]       phase_idx;
    logic [1:0]            quad;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] rom_neg;
    logic [DATA_WIDTH-1:0] fold;

    assign cfg_fire = bus.cfg_valid && cfg_ready;

`ifdef DDS_PHASE_OFFSET_EN
    logic [ACC_WIDTH-1:0] phase_q;
    assign base_phase = phase_q;
    // A config taking effect in the start cycle must also supply the start phase.
    assign start_acc  = cfg_fire ? bus.cfg_phase : phase_q;
`else
    assign base_phase = '0;
    assign start_acc  = '0;
`endif

    // Wrap is judged relative to the start phase so a stopped run ends on a whole cycle.
    assign acc_rel = acc_q - base_phase;
    assign rel_sum = {1'b0, acc_rel} + {1'b0, step_q};
    assign carry   = rel_sum[ACC_WIDTH];

    assign phase_idx = acc_q[ACC_WIDTH-1 -: IdxW];
    assign quad      = phase_idx[IdxW-1 -: 2];
    assign idx       = phase_idx[ADDR_WIDTH-1:0];
    // Quadrants 1 and 3 read the quarter wave backwards.
    assign addr_d    = quad[0] ? ~idx : idx;

    // Lower half mirrors about zero; a zero word would wrap to 0, so pin it to full scale.
    assign rom_neg = ~bus.rom_data + DATA_WIDTH'(1);
    assign fold    = !neg2_q ? bus.rom_data : ((bus.rom_data == '0) ? '1 : rom_neg);

    // Configuration registers, written only through the IDLE handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q  <= '0;
            div_q   <= '0;
`ifdef DDS_PHASE_OFFSET_EN
            phase_q <= '0;
`endif
        end else if (cfg_fire) begin
            step_q  <= bus.cfg_step;
            div_q   <= bus.cfg_div;
`ifdef DDS_PHASE_OFFSET_EN
            phase_q <= bus.cfg_phase;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (bus.start) state_d = StRun;
            StRun:      if (bus.stop) state_d = StStopping;
            StStopping: begin
                if (step_q == '0) begin
                    state_d = StDrain;
                end else if (tick && carry) begin
                    state_d = StDrain;
                end
            end
            StDrain:    if (!v1_q && !v2_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake/busy flags and tick qualification.
    always_comb begin
        cfg_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        tick_slot = (state_q == StRun || state_q == StStopping) && (cnt_q == '0);
        // With a zero step a stopping run can never wrap, so it drains straight away.
        tick      = tick_slot && !(state_q == StStopping && step_q == '0);
    end

    // Divider and accumulator next state; the divider ticks on count 0 so the first
    // RUN cycle always ticks.
    always_comb begin
        cnt_d = '0;
        if ((state_q == StRun || state_q == StStopping) && cnt_q != div_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        acc_d = acc_q;
        if (state_q == StIdle && bus.start) begin
            acc_d = start_acc;
        end else if (tick) begin
            acc_d = acc_q + step_q;
        end
    end

    // Divider and accumulator registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    // Address / ROM / fold pipeline; sample returns to midscale on entry to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            v1_q     <= 1'b0;
            neg1_q   <= 1'b0;
            v2_q     <= 1'b0;
            neg2_q   <= 1'b0;
            sample_q <= MidScale;
            sv_q     <= 1'b0;
        end else begin
            v1_q <= tick;
            if (tick) begin
                addr_q <= addr_d;
                neg1_q <= quad[1];
            end
            v2_q   <= v1_q;
            neg2_q <= neg1_q;
            sv_q   <= v2_q;
            if (v2_q) begin
                sample_q <= fold;
            end else if (state_q != StIdle && state_d == StIdle) begin
                sample_q <= MidScale;
            end
        end
    end

    assign bus.cfg_ready    = cfg_ready;
    assign bus.busy         = busy;
    assign bus.rom_addr     = addr_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = sv_q;
endmodule

// File: tb/tb_dds_sequencer.sv
// Self-checking bench for dds_sequencer: registered ROM model, phase-arithmetic sample model
// feeding an expected-sample queue, and directed runs with hand-computed anchor values.
module tb_dds_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rom [128];
    int   exp_q [$];
    int   got [$];
    int   pulse_cyc [$];
    int   hold = 512;
    int   e_val;
    int   c0;
    int   fall;
    int   n_before;

    dds_sequencer_if bus_if ();

    dds_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered quarter-wave ROM.
    always @(posedge clk) bus_if.rom_data <= 10'(rom[bus_if.rom_addr]);

`ifdef DDS_PHASE_OFFSET_EN
    initial bus_if.cfg_phase = '0;
`endif

    // Sample value implied by a 16-bit phase: 9-bit index, quadrant fold, lower-half mirror.
    function automatic int model_sample(input int unsigned acc);
        int unsigned p, q, i, a;
        int d;
        p = (acc >> 7) & 32'h1ff;
        q = p >> 7;
        i = p & 32'd127;
        a = (q % 2 == 1) ? 127 - i : i;
        d = rom[a];
        if (q >= 2) return (d == 0) ? 1023 : 1024 - d;
        return d;
    endfunction

    // Ticks issued when stop is seen at tick stop_k: keep going until a tick wraps the phase.
    function automatic int n_ticks(input int unsigned step, input int stop_k);
        int unsigned acc = 0;
        for (int k = 0; k < 5000; k++) begin
            if (k > stop_k && acc + step >= 32'd65536) return k + 1;
            acc = (acc + step) % 32'd65536;
        end
        return 0;
    endfunction

    task automatic push_run(input int unsigned step, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(model_sample((k * step) % 32'd65536));
    endtask

    function automatic int got_at(input int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < pulse_cyc.size()) ? pulse_cyc[i] : -1;
    endfunction

    task automatic check(input string name, input int got_v, input int need);
        total++;
        if (got_v != need) begin
            bad++;
            $display("FAIL %s got=%0d need=%0d", name, got_v, need);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_sample"}, int'(bus_if.sample), 512);
        check({p, "_valid"}, int'(bus_if.sample_valid), 0);
        check({p, "_busy"}, int'(bus_if.busy), 0);
        check({p, "_cfg_ready"}, int'(bus_if.cfg_ready), 1);
        check({p, "_rom_addr"}, int'(bus_if.rom_addr), 0);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (bus_if.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(bus_if.busy), 0);
    endtask

    task automatic new_run();
        hold = 512;
        got.delete();
        pulse_cyc.delete();
        exp_q.delete();
    endtask

    // Every pulse must match the model queue; between pulses a busy DUT holds its sample.
    always @(negedge clk) begin
        if (!rst && bus_if.sample_valid) begin
            pulse_cyc.push_back(cyc);
            got.push_back(int'(bus_if.sample));
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected got=%0d need=none", bus_if.sample);
            end else begin
                e_val = exp_q.pop_front();
                hold = e_val;
                if (int'(bus_if.sample) != e_val) begin
                    bad++;
                    $display("FAIL sample_stream got=%0d need=%0d", bus_if.sample, e_val);
                end
            end
        end else if (!rst && bus_if.busy) begin
            total++;
            if (int'(bus_if.sample) != hold) begin
                bad++;
                $display("FAIL sample_hold got=%0d need=%0d", bus_if.sample, hold);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running need=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 128; k++) rom[k] = 512 + 4 * k;
        rst = 1'b1;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_step  = '0;
        bus_if.cfg_div   = '0;
        bus_if.start     = 1'b0;
        bus_if.stop      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // stop alone in IDLE does nothing
        bus_if.stop = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_stop_busy", int'(bus_if.busy), 0);
        bus_if.stop = 1'b0;

        // Run A: step 0x80, div 0, config with start, stop+start at tick 100
        @(negedge clk);
        new_run();
        push_run(32'h80, n_ticks(32'h80, 100));
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_step  = 16'h0080;
        bus_if.cfg_div   = 16'd0;
        bus_if.start     = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus_if.cfg_valid = 1'b0;
        bus_if.start     = 1'b0;
        check("a_run_busy", int'(bus_if.busy), 1);
        check("a_run_cfg_ready", int'(bus_if.cfg_ready), 0);
        repeat (100) @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.stop  = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        wait_idle(2000, "a_idle_timeout");
        fall = cyc;
        check("a_count", got.size(), 512);
        check("a_left", exp_q.size(), 0);
        check("a_first_cyc", cyc_at(0) - c0, 4);
        check("a_consec", cyc_at(3) - cyc_at(0), 3);
        check("a_s0", got_at(0), 512);
        check("a_s1", got_at(1), 516);
        check("a_s2", got_at(2), 520);
        check("a_s3", got_at(3), 524);
        check("a_s128", got_at(128), 1020);
        check("a_s261", got_at(261), 492);
        check("a_s511", got_at(511), 512);
        check("a_busy_fall", fall - cyc_at(511), 1);
        check("a_end_sample", int'(bus_if.sample), 512);
        check("a_end_cfg_ready", int'(bus_if.cfg_ready), 1);
        check("a_end_valid", int'(bus_if.sample_valid), 0);

        // Run B: same config, rom[5]=0 to hit saturation, stop at tick 515 -> full 2 cycles
        rom[5] = 0;
        @(negedge clk);
        new_run();
        push_run(32'h80, n_ticks(32'h80, 515));
        bus_if.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (515) @(negedge clk);
        bus_if.stop = 1'b1;
        @(negedge clk);
        bus_if.stop = 1'b0;
        wait_idle(3000, "b_idle_timeout");
        check("b_count", got.size(), 1024);
        check("b_left", exp_q.size(), 0);
        check("b_s5_zero", got_at(5), 0);
        check("b_s261_sat", got_at(261), 1023);
        check("b_s506_sat", got_at(506), 1023);
        check("b_s512_repeat", got_at(512), 512);
        rom[5] = 512 + 20;

        // Run C: step 0x100, div 3; config refused while busy; reset mid-run
        @(negedge clk);
        new_run();
        push_run(32'h100, 64);
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_step  = 16'h0100;
        bus_if.cfg_div   = 16'd3;
        bus_if.start     = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.cfg_step = 16'h0040;
        bus_if.cfg_div  = 16'd0;
        check("c_busy_cfg_ready", int'(bus_if.cfg_ready), 0);
        @(negedge clk);
        bus_if.cfg_valid = 1'b0;
        repeat (32) @(negedge clk);
        check("c_count", got.size(), 8);
        check("c_first_cyc", cyc_at(0) - c0, 4);
        for (int i = 1; i < 8; i++) check("c_period", cyc_at(i) - cyc_at(i - 1), 4);
        check("c_s1_step_kept", got_at(1), 520);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b0;
        n_before = got.size();
        repeat (8) @(negedge clk);
        check("c_no_inflight", got.size(), n_before);
        check("c_idle_busy", int'(bus_if.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
